// File: rtl/fetch_pkg.sv
// Shared types and widths for the fetch sequencer and its fetch queue.
package fetch_pkg;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 32;
    localparam int ROM_AW  = 8;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_RUN   = 2'd1,
        FS_DRAIN = 2'd2,
        FS_DONE  = 2'd3
    } fetch_state_e;

    // One queue entry: the fetched word and the byte PC it came from (42 bits).
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: ROM address/data, decode handshake, redirect and status.
// Perf counter signals exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_sequencer_if;
    import fetch_pkg::*;

    logic               fetch_en;
    logic [ROM_AW-1:0]  rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]        perf_fetched;
    logic [31:0]        perf_stall;

    modport master (
        input  fetch_en, rom_data, out_ready, redirect, redirect_pc,
        output rom_addr, out_valid, out_instr, out_pc, busy, perf_fetched, perf_stall
    );
    modport slave (
        output fetch_en, rom_data, out_ready, redirect, redirect_pc,
        input  rom_addr, out_valid, out_instr, out_pc, busy, perf_fetched, perf_stall
    );
`else
    modport master (
        input  fetch_en, rom_data, out_ready, redirect, redirect_pc,
        output rom_addr, out_valid, out_instr, out_pc, busy
    );
    modport slave (
        output fetch_en, rom_data, out_ready, redirect, redirect_pc,
        input  rom_addr, out_valid, out_instr, out_pc, busy
    );
`endif

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO for fetched words; flush wins over push/pop, and the head
// output holds its last value while the queue is empty.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 42
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_last;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = i_pop && !o_empty && !i_flush;
    assign w_push  = i_push && (!o_full || w_pop) && !i_flush;
    assign o_head  = o_empty ? r_last : r_mem[r_rd_ptr];

    // NOTE: storage has no reset; only pointers/count define validity, so stale data is never visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (!o_empty) begin
                r_last <= r_mem[r_rd_ptr];
            end
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Front-end fetch sequencer: PC, IDLE/RUN/DRAIN/DONE FSM, redirect handling.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                 DEPTH     = 4,
    parameter logic [INSTR_W-1:0] HALT_WORD = 32'h0000_0000
) (
    input logic               clk,
    input logic               reset,
    fetch_sequencer_if.master bus
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_fetch;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;

    assign w_pop        = !w_empty && bus.out_ready && !bus.redirect;
    assign w_push_entry = '{instr: bus.rom_data, pc: r_pc};

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_fetch),
        .i_pop   (w_pop),
        .i_flush (bus.redirect),
        .i_data  (w_push_entry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_fetch     = 1'b0;
        case (r_state)
            FS_IDLE:  if (bus.fetch_en) w_state_nxt = FS_RUN;
            FS_RUN: begin
                w_fetch = !w_full || w_pop;
                if (w_fetch && bus.rom_data == HALT_WORD) w_state_nxt = FS_DRAIN;
            end
            FS_DRAIN: if (w_empty) w_state_nxt = FS_DONE;
            default:  w_state_nxt = r_state;
        endcase
        // Redirect overrides everything, from any state.
        if (bus.redirect) begin
            w_fetch     = 1'b0;
            w_state_nxt = FS_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= '0;
        end else if (bus.redirect) begin
            r_pc <= bus.redirect_pc & ~PC_W'(3);
        end else if (w_fetch) begin
            r_pc <= r_pc + PC_W'(4);
        end
    end

    assign bus.rom_addr  = r_pc[PC_W-1:2];
    assign bus.out_valid = !w_empty;
    assign bus.out_instr = w_head.instr;
    assign bus.out_pc    = w_head.pc;
    assign bus.busy      = (r_state == FS_RUN) || (r_state == FS_DRAIN);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;
    logic        w_stall;

    assign w_stall = (r_state == FS_RUN) && w_full && !w_pop;

    // Saturating counters; redirect deliberately leaves them alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_fetch && r_perf_fetched != '1) r_perf_fetched <= r_perf_fetched + 1'b1;
            if (w_stall && r_perf_stall != '1)   r_perf_stall   <= r_perf_stall + 1'b1;
        end
    end

    assign bus.perf_fetched = r_perf_fetched;
    assign bus.perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios then random
// stimulus, all compared each cycle against a queue-based reference model.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] HALT  = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_sequencer_if bus();

    fetch_sequencer #(.DEPTH(DEPTH), .HALT_WORD(HALT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] rom [256];
    assign bus.rom_data = rom[bus.rom_addr];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a plain queue of {instr, pc} plus a coarse mode.
    typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} mode_e;
    logic [41:0] m_q[$];
    logic [9:0]  m_pc;
    mode_e       m_mode;
    logic [41:0] m_last;
    longint      m_fetched;
    longint      m_stall;

    task automatic model_step();
        bit pop;
        bit was_empty;
        bit fetch;
        logic [31:0] word;
        if (reset) begin
            m_q.delete();
            m_pc = '0; m_mode = M_IDLE; m_last = '0;
            m_fetched = 0; m_stall = 0;
            return;
        end
        if (m_q.size() > 0) m_last = m_q[0];
        if (bus.redirect) begin
            if (m_mode == M_RUN && m_q.size() == DEPTH && m_stall < 64'hFFFF_FFFF) m_stall++;
            m_q.delete();
            m_pc   = bus.redirect_pc & 10'h3FC;
            m_mode = M_RUN;
            return;
        end
        pop       = (m_q.size() > 0) && bus.out_ready;
        was_empty = (m_q.size() == 0);
        fetch     = (m_mode == M_RUN) && ((m_q.size() < DEPTH) || pop);
        if (m_mode == M_RUN && m_q.size() == DEPTH && !pop && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (pop) void'(m_q.pop_front());
        case (m_mode)
            M_IDLE:  if (bus.fetch_en) m_mode = M_RUN;
            M_RUN: if (fetch) begin
                word = rom[m_pc[9:2]];
                m_q.push_back({word, m_pc});
                m_pc = m_pc + 10'd4;
                if (m_fetched < 64'hFFFF_FFFF) m_fetched++;
                if (word == HALT) m_mode = M_DRAIN;
            end
            M_DRAIN: if (was_empty) m_mode = M_DONE;
            default: ;
        endcase
    endtask

    task automatic compare_all();
        logic [41:0] head;
        head = (m_q.size() > 0) ? m_q[0] : m_last;
        check("out_valid", bus.out_valid, m_q.size() > 0);
        check("out_instr", bus.out_instr, head[41:10]);
        check("out_pc",    bus.out_pc,    head[9:0]);
        check("busy",      bus.busy,      (m_mode == M_RUN) || (m_mode == M_DRAIN));
        check("rom_addr",  bus.rom_addr,  m_pc[9:2]);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", bus.perf_fetched, m_fetched);
        check("perf_stall",   bus.perf_stall,   m_stall);
`endif
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(posedge clk);
            #1;
            compare_all();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = $urandom | 32'h100;
        for (int i = 0; i < 8; i++) rom[i] = 32'h11 + i;
        reset = 1'b1; bus.fetch_en = 1'b0; bus.out_ready = 1'b0;
        bus.redirect = 1'b0; bus.redirect_pc = '0;
        tick(2);
        check("reset_valid", bus.out_valid, 1'b0);
        check("reset_instr", bus.out_instr, 32'h0);
        reset = 1'b0;

        // 1: first valid two cycles after fetch_en, then 1 word/cycle in order.
        bus.fetch_en = 1'b1; bus.out_ready = 1'b1;
        tick(1);
        check("s1_not_yet", bus.out_valid, 1'b0);
        tick(1);
        check("s1_first_valid", bus.out_valid, 1'b1);
        check("s1_first_instr", bus.out_instr, 32'h11);
        tick(1);
        check("s1_second_pc", bus.out_pc, 10'h004);
        tick(8);

        // 2: stalled head fills the queue, then drains without gaps.
        do_reset();
        bus.fetch_en = 1'b1; bus.out_ready = 1'b0;
        tick(1);
        tick(10);
        check("s2_rom_addr",   bus.rom_addr,  8'd4);
        check("s2_head_instr", bus.out_instr, 32'h11);
        check("s2_head_pc",    bus.out_pc,    10'h000);
`ifdef FETCH_PERF_CNT_EN
        check("s2_perf_stall",   bus.perf_stall,   32'd6);
        check("s2_perf_fetched", bus.perf_fetched, 32'd4);
`endif
        bus.out_ready = 1'b1;
        tick(10);

        // 3: redirect with three queued entries and a stalled head.
        do_reset();
        bus.fetch_en = 1'b1; bus.out_ready = 1'b0;
        tick(4);
        bus.redirect = 1'b1; bus.redirect_pc = 10'h041;
        tick(1);
        check("s3_flushed", bus.out_valid, 1'b0);
        bus.redirect = 1'b0;
        tick(1);
        check("s3_valid", bus.out_valid, 1'b1);
        check("s3_pc",    bus.out_pc,    10'h040);
        check("s3_instr", bus.out_instr, rom[16]);
        bus.out_ready = 1'b1;
        tick(4);

        // 4: halt word at address 5 stops fetch; redirect restarts.
        rom[5] = HALT;
        do_reset();
        bus.fetch_en = 1'b1; bus.out_ready = 1'b1;
        tick(15);
        check("s4_busy_low",  bus.busy,     1'b0);
        check("s4_rom_addr",  bus.rom_addr, 8'd6);
        bus.redirect = 1'b1; bus.redirect_pc = 10'h000;
        tick(1);
        check("s4_restart", bus.busy, 1'b1);
        bus.redirect = 1'b0;
        tick(10);
        rom[5] = 32'h16;

        // 5: redirect with a pop pending, then reset mid-stream.
        do_reset();
        bus.fetch_en = 1'b1; bus.out_ready = 1'b1;
        tick(5);
        bus.redirect = 1'b1; bus.redirect_pc = 10'h020;
        tick(1);
        check("s5_no_pop", bus.out_valid, 1'b0);
        bus.redirect = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
        check("s5_rst_valid", bus.out_valid, 1'b0);
        check("s5_rst_pc",    bus.out_pc,    10'h000);
        check("s5_rst_busy",  bus.busy,      1'b0);
        reset = 1'b0;

        // 6: PC wraps from 0x3FC to 0x000.
        bus.redirect = 1'b1; bus.redirect_pc = 10'h3FE;
        tick(1);
        bus.redirect = 1'b0;
        tick(1);
        check("s6_last_pc", bus.out_pc, 10'h3FC);
        tick(1);
        check("s6_wrap_pc", bus.out_pc, 10'h000);
        tick(3);

        // Random phase with a few halt words scattered in the ROM.
        rom[37] = HALT; rom[200] = HALT;
        for (int i = 0; i < 800; i++) begin
            reset           = ($urandom_range(0, 127) == 0);
            bus.fetch_en    = ($urandom_range(0, 3) != 0);
            bus.out_ready   = ($urandom_range(0, 9) < 6);
            bus.redirect    = ($urandom_range(0, 19) == 0);
            bus.redirect_pc = 10'($urandom);
            tick(1);
        end
        reset = 1'b0; bus.redirect = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
